// File: rtl/writeback_rr_q.sv
// rtl/writeback_rr_q.sv - per-channel result FIFOs drained round-robin into a registered RF write port
// Optional per-channel grant/stall counters when WRITEBACK_PERF_CNT_EN is defined.
module writeback_rr_q #(
    parameter int REQ_CHANNELS = 2,
    parameter int FIFO_DEPTH   = 2,
    parameter int VREG_PER_RID = 64,
    parameter int VREG_W       = 6,
    parameter int RID_W        = 2,
    parameter int DATA_W       = 32,
    parameter int GREG_W       = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [REQ_CHANNELS-1:0]          reqs,
    input  logic [REQ_CHANNELS*VREG_W-1:0]   reqVRegIdx,
    input  logic [REQ_CHANNELS*DATA_W-1:0]   reqDataVecs,
    input  logic [REQ_CHANNELS*RID_W-1:0]    reqRID,
    output logic [REQ_CHANNELS-1:0]          stallVec,
    output logic                             RFwen,
    output logic [GREG_W-1:0]                RFwAddr,
    output logic [DATA_W-1:0]                RFwData,
    output logic                             wbValid,
    output logic [RID_W-1:0]                 wbRID,
    output logic [VREG_W-1:0]                wbVreg
`ifdef WRITEBACK_PERF_CNT_EN
    ,
    output logic [REQ_CHANNELS*32-1:0]       perf_grant_cnt,
    output logic [REQ_CHANNELS*32-1:0]       perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (REQ_CHANNELS > 1) ? $clog2(REQ_CHANNELS) : 1;
    localparam int VPR_W = $clog2(VREG_PER_RID);
    localparam int ENT_W = RID_W + VREG_W + DATA_W;

    logic [ENT_W-1:0]  mem_q    [REQ_CHANNELS][FIFO_DEPTH];
    logic [ENT_W-1:0]  mem_d    [REQ_CHANNELS][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [REQ_CHANNELS];
    logic [PTR_W-1:0]  wr_ptr_d [REQ_CHANNELS];
    logic [PTR_W-1:0]  rd_ptr_q [REQ_CHANNELS];
    logic [PTR_W-1:0]  rd_ptr_d [REQ_CHANNELS];
    logic [CNT_W-1:0]  cnt_q    [REQ_CHANNELS];
    logic [CNT_W-1:0]  cnt_d    [REQ_CHANNELS];
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              rfwen_q, rfwen_d;
    logic [GREG_W-1:0] rfwaddr_q, rfwaddr_d;
    logic [DATA_W-1:0] rfwdata_q, rfwdata_d;
    logic [RID_W-1:0]  wbrid_q, wbrid_d;
    logic [VREG_W-1:0] wbvreg_q, wbvreg_d;

    logic [REQ_CHANNELS-1:0] push, pop;
    logic                    found;
    logic [CH_W-1:0]         win;
    logic [ENT_W-1:0]        head;
    logic [RID_W-1:0]        head_rid;
    logic [VREG_W-1:0]       head_vreg;
    int                      idx;

    // First non-empty channel at or after rr_ptr wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < REQ_CHANNELS; k++) begin
            idx = (int'(rr_ptr_q) + k) % REQ_CHANNELS;
            if (!found && cnt_q[idx] != '0) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push     = '0;
        pop      = '0;
        stallVec = '0;
        for (int i = 0; i < REQ_CHANNELS; i++) begin
            stallVec[i] = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            push[i]     = reqs[i] && !stallVec[i];
            pop[i]      = found && (win == CH_W'(i));
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = {reqRID[i*RID_W +: RID_W],
                                         reqVRegIdx[i*VREG_W +: VREG_W],
                                         reqDataVecs[i*DATA_W +: DATA_W]};
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_comb begin
        head      = mem_q[win][rd_ptr_q[win]];
        head_rid  = head[DATA_W+VREG_W +: RID_W];
        head_vreg = head[DATA_W +: VREG_W];
        rfwen_d   = found;
        rfwaddr_d = rfwaddr_q;
        rfwdata_d = rfwdata_q;
        wbrid_d   = wbrid_q;
        wbvreg_d  = wbvreg_q;
        rr_ptr_d  = rr_ptr_q;
        if (found) begin
            // Power-of-two stride lets the RID simply sit above the vreg offset bits.
            rfwaddr_d = (GREG_W'(head_rid) << VPR_W) | GREG_W'(head_vreg[VPR_W-1:0]);
            rfwdata_d = head[DATA_W-1:0];
            wbrid_d   = head_rid;
            wbvreg_d  = head_vreg;
            rr_ptr_d  = (win == CH_W'(REQ_CHANNELS - 1)) ? '0 : win + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REQ_CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q  <= '0;
            rfwen_q   <= 1'b0;
            rfwaddr_q <= '0;
            rfwdata_q <= '0;
            wbrid_q   <= '0;
            wbvreg_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            rfwen_q   <= rfwen_d;
            rfwaddr_q <= rfwaddr_d;
            rfwdata_q <= rfwdata_d;
            wbrid_q   <= wbrid_d;
            wbvreg_q  <= wbvreg_d;
        end
    end

    assign RFwen   = rfwen_q;
    assign wbValid = rfwen_q;
    assign RFwAddr = rfwaddr_q;
    assign RFwData = rfwdata_q;
    assign wbRID   = wbrid_q;
    assign wbVreg  = wbvreg_q;

`ifdef WRITEBACK_PERF_CNT_EN
    logic [31:0] grant_cnt_q [REQ_CHANNELS];
    logic [31:0] grant_cnt_d [REQ_CHANNELS];
    logic [31:0] stall_cnt_q [REQ_CHANNELS];
    logic [31:0] stall_cnt_d [REQ_CHANNELS];

    // Saturating counters: stick at all-ones instead of wrapping.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < REQ_CHANNELS; i++) begin
            if (pop[i] && grant_cnt_q[i] != '1) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
            end
            if (reqs[i] && stallVec[i] && stall_cnt_q[i] != '1) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REQ_CHANNELS; i++) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        perf_stall_cnt = '0;
        for (int i = 0; i < REQ_CHANNELS; i++) begin
            perf_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
            perf_stall_cnt[i*32 +: 32] = stall_cnt_q[i];
        end
    end
`endif

endmodule
